// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_pkg
//  Description : Shared definitions for the add_accumulator_64 slice:
//                default widths, accumulator state encoding and the
//                two's-complement overflow helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_pkg;

    localparam int WIDTH_DEFAULT = 64;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no beats accepted yet
        ST_ACC  = 2'd1,   // accumulating, last beat not seen
        ST_HOLD = 2'd2    // result presented downstream
    } state_t;

    // Signed overflow: operands share a sign and the sum's sign differs.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_acc_core.sv
`default_nettype none
// ============================================================================
//  Module      : add_acc_core
//  Description : Combinational beat adder: {c_out, sum} = acc + in_data + in_c,
//                plus signed-overflow detection on the same sum.
//  Ports       : acc, in_data (WIDTH) - operands
//                in_c                 - carry-in
//                sum (WIDTH)          - result modulo 2^WIDTH
//                c_out                - unsigned carry-out
//                ovf                  - two's-complement overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module add_acc_core
    import add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_c,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, acc} + {1'b0, in_data} + {{WIDTH{1'b0}}, in_c};
    assign sum    = w_full[WIDTH-1:0];
    assign c_out  = w_full[WIDTH];
    // The carry-in is already folded into the sum used for the sign check.
    assign ovf    = signed_ovf(acc[WIDTH-1], in_data[WIDTH-1], w_full[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/add_accumulator_64.sv
`default_nettype none
// ============================================================================
//  Module      : add_accumulator_64
//  Description : Streaming packet accumulator. Sums operand beats arriving on
//                a valid/ready handshake; on the last beat presents the sum,
//                sticky carry/overflow flags and a saturating beat count on
//                an output handshake.
//  Ports       : clk, rst_n (async, active low), clear (sync abort)
//                in_valid/in_ready/in_data/in_c/in_last   - beat input
//                out_valid/out_ready/out_sum/out_c/out_ovf/out_count - result
//  Revision    : 1.0 - initial release
// ============================================================================
module add_accumulator_64
    import add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_c,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc,   w_acc_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_c,     w_c_nxt;
    logic             r_ovf,   w_ovf_nxt;

    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic             w_beat_c;
    logic             w_beat_ovf;

    add_acc_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .acc     (r_acc),
        .in_data (in_data),
        .in_c    (in_c),
        .sum     (w_sum),
        .c_out   (w_beat_c),
        .ovf     (w_beat_ovf)
    );

    // Handshake signals come from the state register only, so in_ready never
    // depends on in_valid.
    assign in_ready  = (r_state != ST_HOLD);
    assign out_valid = (r_state == ST_HOLD);
    assign w_accept  = in_valid && in_ready;

    assign out_sum   = r_acc;
    assign out_c     = r_c;
    assign out_ovf   = r_ovf;
    assign out_count = r_count;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_c_nxt     = r_c;
        w_ovf_nxt   = r_ovf;

        if (clear) begin
            // Abort wins over both a presented beat and a pending take.
            w_state_nxt = ST_IDLE;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_c_nxt     = 1'b0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACC: begin
                    if (w_accept) begin
                        w_acc_nxt   = w_sum;
                        w_c_nxt     = r_c | w_beat_c;
                        w_ovf_nxt   = r_ovf | w_beat_ovf;
                        w_count_nxt = (r_count == C_CNT_MAX) ? r_count
                                                             : r_count + C_CNT_ONE;
                        w_state_nxt = in_last ? ST_HOLD : ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = ST_IDLE;
                        w_acc_nxt   = '0;
                        w_count_nxt = '0;
                        w_c_nxt     = 1'b0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_c_nxt     = 1'b0;
                    w_ovf_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_c     <= w_c_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_accumulator_64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_accumulator_64
//  Description : Directed self-checking bench for add_accumulator_64.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_accumulator_64;

    localparam int WIDTH = 64;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_c;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_c;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    int checks = 0;
    int errors = 0;

    add_accumulator_64 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_c      (in_c),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send_beat(input logic [63:0] d, input logic c, input logic l);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("beat_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_c     = c;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_c     = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [63:0] sum,
                                input logic c, input logic ovf,
                                input logic [15:0] cnt);
        check_value({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check_value({tag, "_sum"},   out_sum, sum);
        check_value({tag, "_c"},     {63'd0, out_c}, {63'd0, c});
        check_value({tag, "_ovf"},   {63'd0, out_ovf}, {63'd0, ovf});
        check_value({tag, "_count"}, {48'd0, out_count}, {48'd0, cnt});
        check_value({tag, "_inrdy"}, {63'd0, in_ready}, 64'd0);
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_value({tag, "_taken_valid"}, {63'd0, out_valid}, 64'd0);
        check_value({tag, "_taken_inrdy"}, {63'd0, in_ready}, 64'd1);
        check_value({tag, "_taken_sum"},   out_sum, 64'd0);
        check_value({tag, "_taken_count"}, {48'd0, out_count}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_c      = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_value("rst_valid", {63'd0, out_valid}, 64'd0);
        check_value("rst_inrdy", {63'd0, in_ready}, 64'd1);
        check_value("rst_sum",   out_sum, 64'd0);
        check_value("rst_count", {48'd0, out_count}, 64'd0);
        check_value("rst_c",     {63'd0, out_c}, 64'd0);
        check_value("rst_ovf",   {63'd0, out_ovf}, 64'd0);

        // Single beat with carry-in: 5 + 1 = 6
        send_beat(64'd5, 1'b1, 1'b1);
        check_result("single", 64'd6, 1'b0, 1'b0, 16'd1);
        take_result("single");

        // All-ones + 1 wraps (carry), then 2 with carry-in: 0 + 2 + 1 = 3
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send_beat(64'd1, 1'b0, 1'b0);
        send_beat(64'd2, 1'b1, 1'b1);
        check_result("three", 64'd3, 1'b1, 1'b0, 16'd3);
        take_result("three");

        // Signed overflow: max positive + 1
        send_beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send_beat(64'd1, 1'b0, 1'b1);
        check_result("ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 16'd2);

        // Back-pressure: hold result while upstream keeps offering a beat
        in_valid = 1'b1;
        in_data  = 64'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_result("bp", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 16'd2);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result("bp");
        send_beat(64'd4, 1'b0, 1'b1);
        check_result("after_bp", 64'd4, 1'b0, 1'b0, 16'd1);
        take_result("after_bp");

        // Clear after two beats, with a third beat presented in that cycle
        send_beat(64'd10, 1'b0, 1'b0);
        send_beat(64'd20, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 64'd30;
        clear    = 1'b1;
        check_value("clr_inrdy", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check_value("clr_valid", {63'd0, out_valid}, 64'd0);
        check_value("clr_sum",   out_sum, 64'd0);
        check_value("clr_count", {48'd0, out_count}, 64'd0);
        send_beat(64'd7, 1'b0, 1'b1);
        check_result("after_clr", 64'd7, 1'b0, 1'b0, 16'd1);

        // Clear while holding drops the result even with out_ready high
        clear     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        out_ready = 1'b0;
        check_value("clr_hold_valid", {63'd0, out_valid}, 64'd0);
        check_value("clr_hold_sum",   out_sum, 64'd0);
        check_value("clr_hold_inrdy", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset in the middle of a packet
        send_beat(64'd100, 1'b1, 1'b0);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        check_value("pre_arst_sum", out_sum, 64'd100);
        check_value("pre_arst_c",   {63'd0, out_c}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_value("arst_sum",   out_sum, 64'd0);
        check_value("arst_count", {48'd0, out_count}, 64'd0);
        check_value("arst_c",     {63'd0, out_c}, 64'd0);
        check_value("arst_inrdy", {63'd0, in_ready}, 64'd1);
        check_value("arst_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(64'd8, 1'b0, 1'b1);
        check_result("after_arst", 64'd8, 1'b0, 1'b0, 16'd1);
        take_result("after_arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
